// File: rtl/aes128_decrypt_iter.sv
// ============================================================================
// aes128_decrypt_iter : iterative AES-128 decryptor, one inverse round/cycle,
// round keys regenerated by inverse key expansion after a forward pass.
// Optional rk10 cache: define AES128_DEC_KEY_CACHE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_DEC    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;

    logic [127:0] rk_fwd;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

`ifdef AES128_DEC_KEY_CACHE_EN
    logic [127:0] key_q, key_d;
    logic [127:0] ckey_q, ckey_d;
    logic [127:0] crk_q, crk_d;
    logic         cval_q, cval_d;
    logic         hit;
`endif

    // ------------------------------------------------------------------
    // GF(2^8) helpers; S-boxes are built from the field inverse + affine map
    // ------------------------------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // x^254 = (x^127)^2 ; maps 0 to 0 as the S-box definition requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] t;
        t = x;
        for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), x);
        return gmul(t, t);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; byte 4c+r is row r, column c
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            o[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            o[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            o[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Key schedule: one forward step and one inverse step of round keys
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        logic [31:0] p0, p1, p2, p3;
        n0 = rk_q[127:96] ^ sub_rot(rk_q[31:0]) ^ {rcon(rcnt_q + 4'd1), 24'h0};
        n1 = rk_q[95:64] ^ n0;
        n2 = rk_q[63:32] ^ n1;
        n3 = rk_q[31:0]  ^ n2;
        rk_fwd = {n0, n1, n2, n3};

        p3 = rk_q[31:0]  ^ rk_q[63:32];
        p2 = rk_q[63:32] ^ rk_q[95:64];
        p1 = rk_q[95:64] ^ rk_q[127:96];
        p0 = rk_q[127:96] ^ sub_rot(p3) ^ {rcon(rcnt_q + 4'd1), 24'h0};
        rk_prev = {p0, p1, p2, p3};
    end

    always_comb begin
        logic [127:0] t;
        t = inv_shift_sub(st_q) ^ rk_prev;
        round_out = (rcnt_q != 4'd0) ? inv_mix(t) : t;
    end

`ifdef AES128_DEC_KEY_CACHE_EN
    assign hit = cval_q && (key == ckey_q);
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= 4'd0;
            rk_q    <= '0;
            st_q    <= '0;
            pt_q    <= '0;
`ifdef AES128_DEC_KEY_CACHE_EN
            key_q   <= '0;
            ckey_q  <= '0;
            crk_q   <= '0;
            cval_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
`ifdef AES128_DEC_KEY_CACHE_EN
            key_q   <= key_d;
            ckey_q  <= ckey_d;
            crk_q   <= crk_d;
            cval_q  <= cval_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rk_d    = rk_q;
        st_d    = st_q;
        pt_d    = pt_q;
`ifdef AES128_DEC_KEY_CACHE_EN
        key_d   = key_q;
        ckey_d  = ckey_q;
        crk_d   = crk_q;
        cval_d  = cval_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef AES128_DEC_KEY_CACHE_EN
                    key_d = key;
                    if (hit) begin
                        st_d    = ciphertext ^ crk_q;
                        rk_d    = crk_q;
                        rcnt_d  = 4'd9;
                        state_d = S_DEC;
                    end else begin
                        st_d    = ciphertext;
                        rk_d    = key;
                        rcnt_d  = 4'd0;
                        state_d = S_KEYEXP;
                    end
`else
                    st_d    = ciphertext;
                    rk_d    = key;
                    rcnt_d  = 4'd0;
                    state_d = S_KEYEXP;
`endif
                end
            end
            S_KEYEXP: begin
                rk_d = rk_fwd;
                if (rcnt_q == 4'd9) begin
                    // initial AddRoundKey folds into the last expansion edge
                    st_d    = st_q ^ rk_fwd;
                    state_d = S_DEC;
`ifdef AES128_DEC_KEY_CACHE_EN
                    ckey_d  = key_q;
                    crk_d   = rk_fwd;
                    cval_d  = 1'b1;
`endif
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            S_DEC: begin
                st_d = round_out;
                rk_d = rk_prev;
                if (rcnt_q == 4'd0) begin
                    pt_d    = round_out;
                    state_d = S_DONE;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign plaintext = pt_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_decrypt_iter.sv
// ============================================================================
// tb_aes128_decrypt_iter : scoreboard bench with FIPS-197 vectors, random
// blocks against a table-driven reference decryptor, backpressure and abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes128_decrypt_iter;

`ifdef AES128_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    aes128_decrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sbq[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [7:0]   tsb [256];
    logic [7:0]   tisb[256];
    bit           cv = 1'b0;
    logic [127:0] ck = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xtm(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input int b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = xtm(x);
        end
        return r;
    endfunction

    // Classic table generator: p walks powers of 3, q walks powers of 3^-1
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            tsb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        tsb[0] = 8'h63;
        for (int i = 0; i < 256; i++) tisb[tsb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_dec(input logic [127:0] c, input logic [127:0] k);
        logic [31:0]  w[44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {tsb[tmp[31:24]], tsb[tmp[23:16]], tsb[tmp[15:8]], tsb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xtm(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    t[4*col+row] = tisb[s[4*((col-row+4)%4)+row]];
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            if (r > 0) begin
                for (int col = 0; col < 4; col++) begin
                    t[4*col+0] = mul(s[4*col],14) ^ mul(s[4*col+1],11) ^ mul(s[4*col+2],13) ^ mul(s[4*col+3],9);
                    t[4*col+1] = mul(s[4*col],9)  ^ mul(s[4*col+1],14) ^ mul(s[4*col+2],11) ^ mul(s[4*col+3],13);
                    t[4*col+2] = mul(s[4*col],13) ^ mul(s[4*col+1],9)  ^ mul(s[4*col+2],14) ^ mul(s[4*col+3],11);
                    t[4*col+3] = mul(s[4*col],11) ^ mul(s[4*col+1],13) ^ mul(s[4*col+2],9)  ^ mul(s[4*col+3],14);
                end
                s = t;
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor ----------------
    bit seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none (cycle %0d)", plaintext, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("plaintext", plaintext, e.pt);
                    chk("latency", 128'(cyc - e.acc), 128'(e.lat));
                end
            end
            if (out_ready) seen = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] pt);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        ciphertext = c;
        key        = k;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
        end else begin
            e.pt  = pt;
            e.acc = cyc + 1;
            e.lat = (CACHE && cv && k == ck) ? 10 : 20;
            cv    = 1'b1;
            ck    = k;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ciphertext = rnd128();
        key        = rnd128();
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sbq.size() == 0 && in_ready && !out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 128'(sbq.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] c, k, pk;
        int           n;
        build_tables();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ciphertext = '0; key = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_plaintext", plaintext, 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // known answers
        send(C1_CT, C1_KEY, C1_PT);
        drain();
        send(B_CT, B_KEY, B_PT);
        drain();

        // backpressure
        out_ready = 1'b0;
        send(C1_CT, C1_KEY, C1_PT);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 15; i++) begin
            chk("bp_plaintext", plaintext, C1_PT);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

        // reset at E12 aborts the block
        k = rnd128();
        @(posedge clk); #1;
        in_valid = 1'b1; ciphertext = C1_CT; key = k;
        @(negedge clk);
        chk("abort_accept", 128'(in_ready), 128'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        cv = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        repeat (25) @(negedge clk);
        chk("abort_no_output", 128'(busy), 128'd0);
        send(C1_CT, C1_KEY, C1_PT);
        drain();

        // in_valid while busy is ignored
        send(B_CT, B_KEY, B_PT);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b1; ciphertext = C1_CT; key = C1_KEY;
        @(negedge clk);
        chk("busy_pulse_in_ready", 128'(in_ready), 128'd0);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // cache scenario (same-key reuse then key change)
        send(C1_CT, C1_KEY, C1_PT);
        drain();
        send(C1_CT, C1_KEY, C1_PT);
        drain();
        send(B_CT, B_KEY, B_PT);
        drain();

        // random blocks, occasionally reusing the previous key
        pk = rnd128();
        for (int i = 0; i < 12; i++) begin
            c = rnd128();
            k = ($urandom_range(0, 2) == 0) ? pk : rnd128();
            send(c, k, ref_dec(c, k));
            pk = k;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryptor: accepts a 128-bit ciphertext and 128-bit cipher key over a valid/ready handshake and returns the FIPS-197 plaintext. It is the inverse counterpart of the unrolled AES-128 encryption path in the design. It trades area for latency by reusing one inverse-round datapath for 10 cycles. The final round key is derived by a forward key-expansion pass, and earlier round keys are regenerated on the fly by inverse key expansion.

## Interface
- No parameters; Nk=4 and Nr=10 are fixed.
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ciphertext/key pair offered
- in_ready  out  1  block idle and able to accept
- ciphertext  in  128  bit 127 = byte 0 of the state (column-major, FIPS-197 order)
- key  in  128  cipher key, same byte order
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  128  decrypted block, same byte order
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, KEYEXP, DEC, DONE.
- **IDLE:** in_ready=1. When in_valid is high, capture ciphertext and key. Load the round-key register with the key and set rcnt=0, then go to KEYEXP.
- **KEYEXP:** each cycle applies one forward KeyExpansion step with Rcon[rcnt+1]; rcnt then increments.
  - On the 10th step the round-key register holds rk10.
  - On the same edge the state register is loaded with ciphertext^rk10, rcnt is set to 9, and the FSM goes to DEC.
- **DEC:** each cycle computes InvShiftRows, then InvSubBytes, then AddRoundKey(rk_prev).
  - rk_prev is the inverse key expansion of the current round key: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[rcnt+1].
  - InvMixColumns is applied afterwards when rcnt≠0.
  - The round-key register takes rk_prev and rcnt decrements.
  - When the cycle with rcnt=0 completes (no InvMixColumns, rk0 applied), the result goes to plaintext and the FSM goes to DONE.
- **DONE:** out_valid=1, and plaintext is held stable until out_ready=1; the FSM then returns to IDLE.
- The datapath is combinational within one cycle: inverse S-box, GF(2^8) multiplies by 9/11/13/14, and a forward S-box for key expansion.
- Inputs are ignored outside IDLE. in_valid during busy has no effect, and nothing is queued.
- Reset mid-operation aborts the block. No output is produced for the aborted block.

## Timing
- Reset values:
  - in_ready=0 during reset, then 1 in the first cycle after rst deasserts.
  - out_valid=0, busy=0, plaintext=0.
  - FSM=IDLE and rcnt=0.
  - Key cache invalid.
- The handshake is accepted at edge E0 (in_valid&in_ready).
  - KEYEXP covers edges E1..E10 and DEC covers edges E11..E20.
  - out_valid rises after E20, giving a latency of 20 cycles.
- in_ready is low from E0 until the cycle after the out_valid&out_ready edge. There is no back-to-back bypass, so the minimum issue interval is 22 cycles when out_ready is tied high.
- With out_ready held low, out_valid and plaintext stay constant indefinitely.

## Configuration
- Macro: `AES128_DEC_KEY_CACHE_EN`.
- **Defined:**
  - The block keeps a 128-bit cached key, a cached rk10 and a cache-valid bit, loaded at the end of KEYEXP.
  - On acceptance, if cache-valid is set and key equals the cached key, KEYEXP is skipped. At E0 the state register is loaded with ciphertext^cached rk10, the round-key register with the cached rk10, rcnt=9, and the FSM goes straight to DEC.
  - Latency on a hit is 10 cycles (out_valid after E10); a miss behaves as the base design.
  - rst clears cache-valid.
- **Not defined:** there is no cache, and every block takes 20 cycles.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff, with out_valid exactly 20 cycles after acceptance.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, ciphertext=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid -> plaintext stable and in_ready=0 throughout; raise out_ready -> in_ready=1 on the following cycle.
- Reset mid-operation: assert rst at E12 -> next cycle in_ready=1, out_valid=0, busy=0. A subsequent C.1 block decrypts correctly in 20 cycles.
- in_valid pulsed while busy with a different ciphertext -> ignored; the original block's plaintext is unaffected.
- With `AES128_DEC_KEY_CACHE_EN` defined:
  - Send C.1 twice with the same key -> the second block's latency is 10 cycles with correct plaintext.
  - Then send the App. B key -> latency 20 cycles.
